mips_mc_controller: RTL

- Multi-cycle MIPS control unit that sequences the 64-bit multi-cycle datapath.
- Decodes op/funct from the instruction register and drives every datapath enable and mux select.
- Gates PC updates with the ALU zero flag.
- Adds an instruction-retire pulse, a retired-instruction counter and an illegal-opcode flag for bench and debug visibility.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_alu_decoder.sv | 35 +++
 rtl/mips_mc_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
// Optional macro MIPS_CTRL_BNE_EN enables the bne state (see mips_mc_controller).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BNEEX  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALUOp/funct to ALUControl mapping; flags unknown funct codes.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_bad
);

    // ALU operation select
    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_bad   = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: begin
                        o_alu_control = ALU_ADD;
                        o_funct_bad   = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with retire counter and sticky illegal-op flag.
// Define MIPS_CTRL_BNE_EN to decode op 000101 (bne) into the BNEEX state.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             Branch,
    output logic             PCSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcB,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;
    logic [1:0]       w_alu_op;
    logic             w_funct_bad;
    logic             w_illegal_set;
    logic             w_taken;
    logic             w_memwrite;
    logic             w_irwrite;
    logic             w_pcwrite;
    logic             w_regwrite;
    logic             w_done;

    mips_alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct       (funct),
        .o_alu_control (ALUControl),
        .o_funct_bad   (w_funct_bad)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next        = r_state;
        w_alu_op      = ALUOP_ADD;
        w_illegal_set = 1'b0;
        w_taken       = zero;
        IorD          = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        Branch        = 1'b0;
        PCSrc         = 1'b0;
        ALUSrcB       = 2'b00;
        ALUSrcA       = 1'b0;
        w_regwrite    = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BNEEX;
`endif
                    default: begin
                        w_next        = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_RTEX: begin
                ALUSrcA       = 1'b1;
                w_alu_op      = ALUOP_FUNCT;
                w_illegal_set = w_funct_bad;
                w_next        = S_RTWB;
            end
            S_RTWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_SUB;
                Branch   = 1'b1;
                PCSrc    = 1'b1;
                w_done   = 1'b1;
                w_taken  = (r_state == S_BNEEX) ? ~zero : zero;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write strobes are suppressed combinationally while reset is held
    assign MemWrite   = reset & w_memwrite;
    assign IRWrite    = reset & w_irwrite;
    assign PCWrite    = reset & w_pcwrite;
    assign RegWrite   = reset & w_regwrite;
    assign instr_done = reset & w_done;
    assign PCEn       = reset & (w_pcwrite | (Branch & w_taken));

    // Retired-instruction counter and sticky illegal flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= {CNT_W{1'b0}};
            r_illegal <= 1'b0;
        end else begin
            if (w_done) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign retired    = r_retired;
    assign illegal_op = r_illegal;

endmodule
